// File: rtl/rom_ctrl_pkg.sv
// Shared defaults, FSM encoding and requester ids for the ROM burst arbiter.
package rom_ctrl_pkg;

  localparam int AW_DEFAULT = 14;
  localparam int DW_DEFAULT = 24;
  localparam int LW_DEFAULT = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Requester, ROM and read-return signals of the ROM burst arbiter.
interface rom_burst_arbiter_if #(
  parameter int AW = rom_ctrl_pkg::AW_DEFAULT,
  parameter int DW = rom_ctrl_pkg::DW_DEFAULT,
  parameter int LW = rom_ctrl_pkg::LW_DEFAULT
);
  logic          req0;
  logic [AW-1:0] addr0;
  logic [LW-1:0] len0;
  logic          ack0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [LW-1:0] len1;
  logic          ack1;
  logic [AW-1:0] rom_addr;
  logic          rom_re;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_id;
  logic          rd_last;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  req0, addr0, len0, req1, addr1, len1, rom_data,
    output ack0, ack1, rom_addr, rom_re, rd_data, rd_valid, rd_id, rd_last, busy
  );

  // Requesters, ROM and consumers.
  modport master (
    output req0, addr0, len0, req1, addr1, len1, rom_data,
    input  ack0, ack1, rom_addr, rom_re, rd_data, rd_valid, rd_id, rd_last, busy
  );
endinterface

// File: rtl/rom_burst_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
  import rom_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_id,
  output logic       gnt_valid
);

  logic last_gnt;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = REQ0;
    if (req == 2'b10)      gnt_id = REQ1;
    else if (req == 2'b11) gnt_id = ~last_gnt;
  end

  // Resetting to REQ1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last_gnt <= REQ1;
    else if (grant_en) last_gnt <= gnt_id;
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one registered-output ROM between two burst requesters and tags the
// returned words with the owning requester.
module rom_burst_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int LW = LW_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  rom_burst_arbiter_if.slave bus
);

  state_t        state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic          id_q;
  logic          gnt_id;
  logic          gnt_valid;
  logic          grant_en;
  logic [DW-1:0] rd_word;

  assign grant_en = (state == IDLE) && gnt_valid;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({bus.req1, bus.req0}),
    .grant_en  (grant_en),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // The ROM output register already provides the one-cycle alignment.
  assign rd_word     = bus.rom_data;
  assign bus.rd_data = rd_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      len_q        <= '0;
      id_q         <= REQ0;
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      bus.rom_addr <= '0;
      bus.rom_re   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.rd_id    <= 1'b0;
      bus.rd_last  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rom_re;
      bus.rd_id    <= id_q;
      bus.rd_last  <= bus.rom_re && (cnt == len_q);
      bus.ack0     <= 1'b0;
      bus.ack1     <= 1'b0;
      case (state)
        IDLE: begin
          bus.rom_re   <= 1'b0;
          bus.busy     <= 1'b0;
          bus.rom_addr <= '0;
          cnt          <= '0;
          if (gnt_valid) begin
            state        <= BURST;
            id_q         <= gnt_id;
            bus.rom_addr <= (gnt_id == REQ1) ? bus.addr1 : bus.addr0;
            len_q        <= (gnt_id == REQ1) ? bus.len1 : bus.len0;
            bus.rom_re   <= 1'b1;
            bus.busy     <= 1'b1;
            bus.ack0     <= (gnt_id == REQ0);
            bus.ack1     <= (gnt_id == REQ1);
          end
        end
        BURST: begin
          if (cnt == len_q) begin
            state        <= IDLE;
            bus.rom_re   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.rom_addr <= '0;
            cnt          <= '0;
          end else begin
            cnt          <= cnt + LW'(1);
            bus.rom_addr <= bus.rom_addr + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter: table of burst scenarios checked
// against a small timing/data model, plus a reset-mid-burst sequence.
module tb_rom_burst_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_burst_arbiter_if #(.AW(14), .DW(24), .LW(8)) bus ();

  rom_burst_arbiter #(.AW(14), .DW(24), .LW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM holds memory[i] = i, registered output.
  always @(posedge clk) if (bus.rom_re) bus.rom_data <= {10'd0, bus.rom_addr};

  typedef struct {
    logic        id;
    logic [23:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  beat_t beats[$];
  int    ack_c[$];
  logic  ack_i[$];
  int    busy_cnt = 0;
  bit    mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ack0) begin ack_c.push_back(cyc); ack_i.push_back(1'b0); end
      if (bus.ack1) begin ack_c.push_back(cyc); ack_i.push_back(1'b1); end
      if (bus.rd_valid) beats.push_back('{bus.rd_id, bus.rd_data, bus.rd_last, cyc});
      if (bus.busy) busy_cnt++;
    end
  end

  typedef struct {
    bit          do_reset;
    bit          hold;
    logic        r0;
    logic [13:0] a0;
    logic [7:0]  l0;
    logic        r1;
    logic [13:0] a1;
    logic [7:0]  l1;
    int          n;
    logic [5:0]  gseq;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int start, ack_b, beat_b, busy_b, exp_ack, exp_busy, exp_beats, bi, budget, nack;
    logic        gid;
    logic [7:0]  glen;
    logic [13:0] gaddr;
    string       tag;
    tag = $sformatf("v%0d", vi);
    if (v.do_reset) apply_reset();
    @(negedge clk);
    ack_b  = ack_c.size();
    beat_b = beats.size();
    busy_b = busy_cnt;
    start  = cyc;
    bus.req0 = v.r0; bus.addr0 = v.a0; bus.len0 = v.l0;
    bus.req1 = v.r1; bus.addr1 = v.a1; bus.len1 = v.l1;
    budget = 10;
    for (int g = 0; g < v.n; g++)
      budget += int'(v.gseq[g] ? v.l1 : v.l0) + 2;
    nack = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!v.hold) begin
        if (bus.ack0) bus.req0 = 1'b0;
        if (bus.ack1) bus.req1 = 1'b0;
      end else begin
        if (bus.ack0 || bus.ack1) nack++;
        if (nack >= v.n) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      end
    end
    #1;
    chk({tag, "_ack_count"}, ack_c.size() - ack_b, v.n);
    exp_ack = start + 1;
    exp_busy = 0;
    exp_beats = 0;
    bi = beat_b;
    for (int g = 0; g < v.n; g++) begin
      gid   = v.gseq[g];
      glen  = gid ? v.l1 : v.l0;
      gaddr = gid ? v.a1 : v.a0;
      if (ack_b + g < ack_c.size()) begin
        chk({tag, "_ack_id"}, ack_i[ack_b + g], gid);
        chk({tag, "_ack_cycle"}, ack_c[ack_b + g], exp_ack);
      end
      for (int j = 0; j <= int'(glen); j++) begin
        if (bi < beats.size()) begin
          chk({tag, "_rd_data"}, beats[bi].data, {10'd0, gaddr + 14'(j)});
          chk({tag, "_rd_id"}, beats[bi].id, gid);
          chk({tag, "_rd_last"}, beats[bi].last, (j == int'(glen)));
          chk({tag, "_rd_cycle"}, beats[bi].cyc, exp_ack + 1 + j);
        end
        bi++;
      end
      exp_beats += int'(glen) + 1;
      exp_busy  += int'(glen) + 1;
      exp_ack   += int'(glen) + 2;
    end
    chk({tag, "_beat_count"}, beats.size() - beat_b, exp_beats);
    chk({tag, "_busy_cycles"}, busy_cnt - busy_b, exp_busy);
  endtask

  initial begin
    int   nv;
    int   late;
    vec_t tv;

    // do_reset, hold, r0, a0, l0, r1, a1, l1, n, grant order (bit g = grant g)
    vecs[0] = '{0, 0, 1'b1, 14'h0010, 8'd3,   1'b0, 14'h0000, 8'd0, 1, 6'b000000};
    vecs[1] = '{1, 0, 1'b1, 14'h0100, 8'd1,   1'b1, 14'h0200, 8'd1, 2, 6'b000010};
    vecs[2] = '{0, 0, 1'b0, 14'h0000, 8'd0,   1'b1, 14'h3FFE, 8'd3, 1, 6'b000001};
    vecs[3] = '{0, 0, 1'b0, 14'h0000, 8'd0,   1'b1, 14'h0005, 8'd0, 1, 6'b000001};
    vecs[4] = '{0, 0, 1'b1, 14'h0040, 8'd0,   1'b0, 14'h0000, 8'd0, 1, 6'b000000};
    vecs[5] = '{0, 0, 1'b1, 14'h00A0, 8'd0,   1'b1, 14'h00B0, 8'd2, 2, 6'b000001};
    vecs[6] = '{1, 1, 1'b1, 14'h0300, 8'd0,   1'b1, 14'h0400, 8'd0, 6, 6'b101010};
    vecs[7] = '{0, 0, 1'b1, 14'h1000, 8'd255, 1'b0, 14'h0000, 8'd0, 1, 6'b000000};

    bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = '0;
    bus.rom_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_ack0", bus.ack0, 1'b0);
    chk("rst_ack1", bus.ack1, 1'b0);
    chk("rst_rom_re", bus.rom_re, 1'b0);
    chk("rst_rom_addr", bus.rom_addr, 14'h0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_id", bus.rd_id, 1'b0);
    chk("rst_rd_last", bus.rd_last, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rom_re", bus.rom_re, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a 16-word burst.
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 14'h0000; bus.len0 = 8'd15;
    nv = 0;
    for (int c = 0; c < 40 && nv < 5; c++) begin
      @(negedge clk);
      if (bus.ack0) bus.req0 = 1'b0;
      if (bus.rd_valid) nv++;
    end
    chk("mid_beats_before_rst", nv, 5);
    chk("mid_rom_re_before_rst", bus.rom_re, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rom_re", bus.rom_re, 1'b0);
    chk("mid_rd_valid", bus.rd_valid, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    late = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.rd_valid || bus.rom_re || bus.busy) late++;
    end
    chk("mid_activity_after_release", late, 0);

    tv = '{0, 0, 1'b1, 14'h0050, 8'd0, 1'b1, 14'h0060, 8'd0, 2, 6'b000010};
    run_vec(8, tv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
